// File: rtl/fir_mac_sched_if.sv
// Signal bundle between the FIR MAC sequencer, the sample source, the
// coefficient ROM and the output consumer. The master side is the
// surrounding system; the slave side is the sequencer itself.
interface fir_mac_sched_if #(
    parameter int NTAPS  = 32,
    parameter int DATA_W = 16
);
    localparam int ADDR_W = $clog2(NTAPS);

    logic                     sample_valid;
    logic signed [DATA_W-1:0] sample_in;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [DATA_W-1:0] coef_data;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;
    logic                     clear_ovr;

    modport master (
        output sample_valid, sample_in, coef_data, clear_ovr,
        input  coef_addr, sample_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_valid, sample_in, coef_data, clear_ovr,
        output coef_addr, sample_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/fir_mac_sched.sv
// Sequencer for one shared multiply-accumulate unit implementing an NTAPS-tap
// FIR filter. Each new sample is written into a circular delay line, then the
// coefficient ROM is walked one tap per cycle, the sum is saturated to DATA_W
// bits and presented with a one-cycle valid strobe. One extra sample can wait
// in a pending slot while a computation is in flight; further samples are
// dropped and flagged on the sticky overrun bit.
module fir_mac_sched #(
    parameter int NTAPS  = 32,
    parameter int DATA_W = 16
) (
    input  logic           main_clk,
    input  logic           reset,
    fir_mac_sched_if.slave bus
);
    localparam int ADDR_W = $clog2(NTAPS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int SHIFT  = DATA_W - 1;
    localparam int SH_W   = ACC_W - SHIFT;

    localparam logic [ADDR_W-1:0]      LAST_TAP = ADDR_W'(NTAPS - 1);
    localparam logic signed [SH_W-1:0] SAT_MAX  = SH_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SH_W-1:0] SAT_MIN  = SH_W'(-(2 ** (DATA_W - 1)));
    localparam logic [DATA_W-1:0]      OUT_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]      OUT_MIN  = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] delay_line [NTAPS];
    logic        [ADDR_W-1:0] wr_ptr;
    logic        [ADDR_W-1:0] k;
    logic signed [ACC_W-1:0]  acc;
    logic                     pend_v;
    logic signed [DATA_W-1:0] pend_data;
    logic signed [DATA_W-1:0] sample_out_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    logic        [ADDR_W-1:0] wr_next;
    logic        [ADDR_W-1:0] tap_idx;
    logic        [ADDR_W-1:0] rd_idx;
    logic signed [DATA_W-1:0] rd_sample;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [SH_W-1:0]   acc_shift;
    logic signed [DATA_W-1:0] sat_val;
    logic                     is_running;
    logic                     slot_freed;
    logic                     capture;
    logic                     drop;
    logic signed [DATA_W-1:0] start_data;

    assign bus.coef_addr  = k;
    assign bus.sample_out = sample_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

    // Datapath: pick the delay-line sample matching the coefficient now on
    // coef_data, form the product, accumulate and saturate the shifted sum.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        wr_next   = wr_ptr + 1'b1;
        // coef_data lags coef_addr by one cycle, so in MAC the product belongs
        // to tap k-1; in DRAIN k has stopped at the last tap and is used as is.
        tap_idx   = (state == S_DRAIN) ? k : k - 1'b1;
        rd_idx    = wr_ptr - tap_idx;
        rd_sample = delay_line[rd_idx];
        product   = PROD_W'(bus.coef_data) * PROD_W'(rd_sample);
        acc_next  = acc + ACC_W'(product);
        acc_shift = SH_W'(acc_next >>> SHIFT);
        sat_val   = acc_shift[DATA_W-1:0];
        if (acc_shift > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (acc_shift < SAT_MIN) begin
            sat_val = OUT_MIN;
        end
    end

    // Sample-admission control: a pending sample always goes first, and the
    // slot it vacates may be refilled by a sample arriving in the same cycle.
    always_comb begin
        is_running = (state == S_MAC) || (state == S_DRAIN);
        slot_freed = pend_v && ((state == S_IDLE) || (state == S_DONE));
        capture    = bus.sample_valid &&
                     (((state == S_IDLE) && pend_v) || (state == S_DONE) ||
                      (is_running && !pend_v));
        drop       = bus.sample_valid && pend_v && is_running;
        start_data = pend_v ? pend_data : bus.sample_in;
    end

    // Sequencer FSM with delay line, accumulator, pending slot and registered outputs.
    always_ff @(posedge main_clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // read sees the value from before this edge, regardless of statement order.
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            k            <= '0;
            acc          <= '0;
            pend_v       <= 1'b0;
            pend_data    <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            // NOTE: the delay line is cleared on reset so the first outputs after
            // reset see silence in the older taps instead of stale samples.
            for (int i = 0; i < NTAPS; i++) begin
                delay_line[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;

            // A drop in the same cycle as clear_ovr keeps the flag set.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clear_ovr) begin
                overrun_q <= 1'b0;
            end

            if (capture) begin
                pend_v    <= 1'b1;
                pend_data <= bus.sample_in;
            end else if (slot_freed) begin
                pend_v    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend_v || bus.sample_valid) begin
                        delay_line[wr_ptr] <= start_data;
                        acc    <= '0;
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= S_MAC;
                    end
                end

                S_MAC: begin
                    if (k != '0) begin
                        acc <= acc_next;
                    end
                    if (k == LAST_TAP) begin
                        state <= S_DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                S_DRAIN: begin
                    acc          <= acc_next;
                    sample_out_q <= sat_val;
                    out_valid_q  <= 1'b1;
                    state        <= S_DONE;
                end

                S_DONE: begin
                    wr_ptr <= wr_next;
                    if (pend_v) begin
                        delay_line[wr_next] <= pend_data;
                        acc   <= '0;
                        k     <= '0;
                        state <= S_MAC;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: a 4-tap instance for impulse,
// latency, saturation, back-to-back/overrun and reset-abort cases, and a
// 32-tap instance for delay-line wrap. Expected results are queued when a
// sample is driven and compared when out_valid is seen.
module tb_fir_mac_sched;
    logic main_clk = 1'b0;
    logic reset;

    always #5 main_clk = ~main_clk;

    fir_mac_sched_if #(.NTAPS(4),  .DATA_W(16)) bus4 ();
    fir_mac_sched_if #(.NTAPS(32), .DATA_W(16)) bus32 ();

    fir_mac_sched #(.NTAPS(4), .DATA_W(16)) dut4 (
        .main_clk (main_clk),
        .reset    (reset),
        .bus      (bus4.slave)
    );

    fir_mac_sched #(.NTAPS(32), .DATA_W(16)) dut32 (
        .main_clk (main_clk),
        .reset    (reset),
        .bus      (bus32.slave)
    );

    // Coefficient ROMs with one cycle of read latency.
    logic [15:0] rom4  [4];
    logic [15:0] rom32 [32];

    always @(posedge main_clk) begin
        bus4.coef_data  <= rom4[bus4.coef_addr];
        bus32.coef_data <= rom32[bus32.coef_addr];
    end

    logic [15:0] q4  [$];
    logic [15:0] q32 [$];
    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        bit          rst_first;
        logic [15:0] coef;
        logic [15:0] smp;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge main_clk) begin
        if (reset === 1'b0 && bus4.out_valid === 1'b1) begin
            check("dut4 out_valid has a queued result", {31'b0, q4.size() != 0}, 32'd1);
            if (q4.size() != 0) begin
                logic [15:0] e;
                e = q4.pop_front();
                check("dut4 sample_out", {16'b0, bus4.sample_out}, {16'b0, e});
            end
        end
        if (reset === 1'b0 && bus32.out_valid === 1'b1) begin
            check("dut32 out_valid has a queued result", {31'b0, q32.size() != 0}, 32'd1);
            if (q32.size() != 0) begin
                logic [15:0] e;
                e = q32.pop_front();
                check("dut32 sample_out", {16'b0, bus32.sample_out}, {16'b0, e});
            end
        end
    end

    task automatic next_cycle();
        @(posedge main_clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus4.sample_valid  = 1'b0;
        bus4.clear_ovr     = 1'b0;
        bus32.sample_valid = 1'b0;
        bus32.clear_ovr    = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        q4.delete();
        q32.delete();
    endtask

    task automatic pulse4(input logic [15:0] s);
        bus4.sample_valid = 1'b1;
        bus4.sample_in    = s;
        next_cycle();
        bus4.sample_valid = 1'b0;
    endtask

    task automatic pulse32(input logic [15:0] s);
        bus32.sample_valid = 1'b1;
        bus32.sample_in    = s;
        next_cycle();
        bus32.sample_valid = 1'b0;
    endtask

    task automatic wait_done4(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge main_clk);
            if (q4.size() == 0 && bus4.busy === 1'b0) done = 1'b1;
        end
        check("dut4 finishes within budget", {31'b0, done}, 32'd1);
        next_cycle();
    endtask

    task automatic wait_done32(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge main_clk);
            if (q32.size() == 0 && bus32.busy === 1'b0) done = 1'b1;
        end
        check("dut32 finishes within budget", {31'b0, done}, 32'd1);
        next_cycle();
    endtask

    task automatic set_rom4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) rom4[i] = c;
    endtask

    task automatic apply_vec(input vec_t v, input bit allow_rst);
        if (v.rst_first && allow_rst) do_reset();
        set_rom4(v.coef);
        q4.push_back(v.exp);
        pulse4(v.smp);
        wait_done4(20);
    endtask

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Impulse response, then saturation in both directions.
        vecs[0]  = '{1'b1, 16'h4000, 16'h2000, 16'h1000};
        vecs[1]  = '{1'b0, 16'h4000, 16'h0000, 16'h1000};
        vecs[2]  = '{1'b0, 16'h4000, 16'h0000, 16'h1000};
        vecs[3]  = '{1'b0, 16'h4000, 16'h0000, 16'h1000};
        vecs[4]  = '{1'b0, 16'h4000, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFE};
        vecs[6]  = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[7]  = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[8]  = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[9]  = '{1'b0, 16'h7FFF, 16'h8000, 16'h7FFF};
        vecs[10] = '{1'b0, 16'h7FFF, 16'h8000, 16'hFFFE};
        vecs[11] = '{1'b0, 16'h7FFF, 16'h8000, 16'h8000};
        vecs[12] = '{1'b0, 16'h7FFF, 16'h8000, 16'h8000};

        reset = 1'b1;
        bus4.sample_valid  = 1'b0;
        bus4.sample_in     = '0;
        bus4.clear_ovr     = 1'b0;
        bus32.sample_valid = 1'b0;
        bus32.sample_in    = '0;
        bus32.clear_ovr    = 1'b0;
        set_rom4(16'h0000);
        for (int i = 0; i < 32; i++) rom32[i] = 16'h0000;
        rom32[0] = 16'h7FFF;
        @(posedge main_clk);
        #1;
        do_reset();

        // Reset state.
        @(negedge main_clk);
        check("reset sample_out", {16'b0, bus4.sample_out}, 32'h0);
        check("reset out_valid", {31'b0, bus4.out_valid}, 32'h0);
        check("reset busy", {31'b0, bus4.busy}, 32'h0);
        check("reset overrun", {31'b0, bus4.overrun}, 32'h0);
        check("reset coef_addr", {30'b0, bus4.coef_addr}, 32'h0);
        check("reset dut32 busy", {31'b0, bus32.busy}, 32'h0);
        next_cycle();

        // Impulse and saturation tables.
        for (int i = 0; i < 13; i++) apply_vec(vecs[i], 1'b1);

        // Latency: sample in cycle 0, result only in cycle 6.
        do_reset();
        set_rom4(16'h4000);
        q4.push_back(16'h1000);
        pulse4(16'h2000);
        for (int i = 1; i <= 8; i++) begin
            @(negedge main_clk);
            check($sformatf("latency out_valid cycle %0d", i), {31'b0, bus4.out_valid}, {31'b0, i == 6});
            check($sformatf("latency busy cycle %0d", i), {31'b0, bus4.busy}, {31'b0, i <= 6});
            if (i <= 4) check($sformatf("latency coef_addr cycle %0d", i), {30'b0, bus4.coef_addr}, i - 1);
        end
        next_cycle();

        // Back-to-back: second sample waits, third is dropped, clear_ovr,
        // then a drop coinciding with clear_ovr keeps overrun set.
        do_reset();
        set_rom4(16'h4000);
        for (int i = 0; i <= 13; i++) begin
            bus4.sample_valid = (i == 0) || (i == 2) || (i == 3) || (i == 5);
            bus4.sample_in    = (i == 0) ? 16'h2000 : (i == 2) ? 16'h1000 :
                                (i == 3) ? 16'h7000 : 16'h5000;
            bus4.clear_ovr    = (i == 4) || (i == 5);
            if (i == 0) q4.push_back(16'h1000);
            if (i == 2) q4.push_back(16'h1800);
            @(negedge main_clk);
            check($sformatf("b2b out_valid cycle %0d", i), {31'b0, bus4.out_valid}, {31'b0, (i == 6) || (i == 12)});
            check($sformatf("b2b busy cycle %0d", i), {31'b0, bus4.busy}, {31'b0, (i >= 1) && (i <= 12)});
            check($sformatf("b2b overrun cycle %0d", i), {31'b0, bus4.overrun}, {31'b0, (i == 4) || (i >= 6)});
            next_cycle();
        end
        bus4.sample_valid = 1'b0;
        bus4.clear_ovr    = 1'b0;
        check("b2b all results seen", q4.size(), 32'd0);

        // Reset in the middle of MAC aborts the computation.
        do_reset();
        set_rom4(16'h4000);
        pulse4(16'h2000);
        repeat (2) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge main_clk);
        check("abort busy after reset", {31'b0, bus4.busy}, 32'h0);
        check("abort coef_addr after reset", {30'b0, bus4.coef_addr}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge main_clk);
            check($sformatf("abort out_valid +%0d", i), {31'b0, bus4.out_valid}, 32'h0);
        end
        next_cycle();
        for (int i = 0; i < 5; i++) apply_vec(vecs[i], 1'b0);

        // Delay-line wrap on the 32-tap instance: only tap 0 is non-zero.
        for (int x = 1; x <= 96; x++) begin
            int prod;
            prod = x * 32767;
            q32.push_back(16'(prod >>> 15));
            pulse32(16'(x));
            wait_done32(60);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
